// File: rtl/uart_rx_interface_if.sv
// UART receiver / ALU front-end signal bundle.
// Serial line and transmitter handshake grouped for the top level.
interface uart_rx_interface_if #(
  parameter int NB_BITS = 8
);
  logic               i_rx;
  logic               i_tx_done;
  logic               o_rate;
  logic [NB_BITS-1:0] o_rx_data;
  logic               o_rx_done;
  logic [NB_BITS-1:0] o_data;
  logic               o_tx_start;

  modport master (
    output i_rx,
    output i_tx_done,
    input  o_rate,
    input  o_rx_data,
    input  o_rx_done,
    input  o_data,
    input  o_tx_start
  );

  modport slave (
    input  i_rx,
    input  i_tx_done,
    output o_rate,
    output o_rx_data,
    output o_rx_done,
    output o_data,
    output o_tx_start
  );
endinterface

// File: rtl/uart_rx_interface.sv
// Oversampling 8N1 UART receiver feeding a three-byte A/OP/B ALU
// sequencer whose result is handed to an external transmitter.
module uart_rx_interface #(
  parameter int NB_BITS   = 8,
  parameter int N_TICK    = 325,
  parameter int N_SAMPLES = 16
) (
  input logic             i_clk,
  input logic             i_rst,
  uart_rx_interface_if.slave bus
);

  localparam int TW = (N_TICK > 1) ? $clog2(N_TICK) : 1;
  localparam int SW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam int NW = $clog2(NB_BITS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(N_TICK - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(N_SAMPLES - 1);
  localparam logic [SW-1:0] S_HALF    = SW'(N_SAMPLES / 2 - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(NB_BITS - 1);

  localparam logic [NB_BITS-1:0] OP_ADD = NB_BITS'(8'h20);
  localparam logic [NB_BITS-1:0] OP_SUB = NB_BITS'(8'h22);
  localparam logic [NB_BITS-1:0] OP_AND = NB_BITS'(8'h24);
  localparam logic [NB_BITS-1:0] OP_OR  = NB_BITS'(8'h25);
  localparam logic [NB_BITS-1:0] OP_XOR = NB_BITS'(8'h26);
  localparam logic [NB_BITS-1:0] OP_NOR = NB_BITS'(8'h27);
  localparam logic [NB_BITS-1:0] OP_SRA = NB_BITS'(8'h03);
  localparam logic [NB_BITS-1:0] OP_SRL = NB_BITS'(8'h02);

  // ---------------- tick generator ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick       = (tick_cnt == TICK_LAST);
  assign bus.o_rate = tick;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_t;

  rx_state_t          rx_state;
  logic [SW-1:0]      s_cnt;
  logic [NW-1:0]      n_cnt;
  logic [NB_BITS-1:0] shreg;
  logic [NB_BITS-1:0] rx_data;
  logic               rx_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state <= R_IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick) begin
        unique case (rx_state)
          R_IDLE: begin
            if (!bus.i_rx) begin
              rx_state <= R_START;
              s_cnt    <= '0;
            end
          end
          R_START: begin
            // mid-start-bit recheck filters short line glitches
            if (s_cnt == S_HALF) begin
              if (!bus.i_rx) begin
                rx_state <= R_DATA;
                s_cnt    <= '0;
                n_cnt    <= '0;
              end else begin
                rx_state <= R_IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (s_cnt == S_LAST) begin
              s_cnt <= '0;
              shreg <= {bus.i_rx, shreg[NB_BITS-1:1]};
              if (n_cnt == N_LAST) begin
                rx_state <= R_STOP;
              end else begin
                n_cnt <= n_cnt + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (s_cnt == S_LAST) begin
              if (bus.i_rx) begin
                rx_data <= shreg;
                rx_done <= 1'b1;
              end
              rx_state <= R_IDLE;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
          default: rx_state <= R_IDLE;
        endcase
      end
    end
  end

  assign bus.o_rx_data = rx_data;
  assign bus.o_rx_done = rx_done;

  // ---------------- ALU ----------------
  logic [NB_BITS-1:0] opa;
  logic [NB_BITS-1:0] opc;
  logic [NB_BITS-1:0] opb;
  logic [NB_BITS-1:0] result;

  always_comb begin
    result = '0;
    unique case (opc)
      OP_ADD:  result = opa + opb;
      OP_SUB:  result = opa - opb;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_NOR:  result = ~(opa | opb);
      OP_SRA:  result = $unsigned($signed(opa) >>> opb);
      OP_SRL:  result = opa >> opb;
      default: result = '0;
    endcase
  end

  // ---------------- operand sequencer ----------------
  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_OP,
    WAIT_B,
    SEND,
    WAIT_TX
  } if_state_t;

  if_state_t          if_state;
  logic [NB_BITS-1:0] data;
  logic               tx_start;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      if_state <= WAIT_A;
      opa      <= '0;
      opc      <= '0;
      opb      <= '0;
      data     <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      unique case (if_state)
        WAIT_A: begin
          if (rx_done) begin
            opa      <= rx_data;
            if_state <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (rx_done) begin
            opc      <= rx_data;
            if_state <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (rx_done) begin
            opb      <= rx_data;
            if_state <= SEND;
          end
        end
        SEND: begin
          data     <= result;
          tx_start <= 1'b1;
          if_state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.i_tx_done) begin
            if_state <= WAIT_A;
          end
        end
        default: if_state <= WAIT_A;
      endcase
    end
  end

  assign bus.o_data     = data;
  assign bus.o_tx_start = tx_start;

endmodule

// File: tb/tb_uart_rx_interface.sv
// Randomized scoreboard bench for uart_rx_interface with a
// byte-level reference model of the operand sequencer and ALU.
module tb_uart_rx_interface;

  localparam int NB  = 8;
  localparam int NT  = 5;
  localparam int NS  = 16;
  localparam int BIT = NT * NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_interface_if #(.NB_BITS(NB)) bus ();

  uart_rx_interface #(
    .NB_BITS  (NB),
    .N_TICK   (NT),
    .N_SAMPLES(NS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_rx[$];
  int         exp_t[$];
  logic [7:0] exp_tx[$];

  logic [7:0] ops[3];
  int         nacc = 0;
  bit         busy = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_alu(input logic [7:0] a,
                                         input logic [7:0] op,
                                         input logic [7:0] b);
    int ia;
    int ib;
    int sa;
    int r;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    case (op)
      8'h20:   r = ia + ib;
      8'h22:   r = ia - ib;
      8'h24:   r = ia & ib;
      8'h25:   r = ia | ib;
      8'h26:   r = ia ^ ib;
      8'h27:   r = ~(ia | ib);
      8'h03:   r = sa >>> ((ib > 31) ? 31 : ib);
      8'h02:   r = (ib > 31) ? 0 : (ia >> ib);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic model_accept(input logic [7:0] v, input int t0);
    exp_rx.push_back(v);
    exp_t.push_back(t0);
    if (!busy) begin
      ops[nacc] = v;
      nacc++;
      if (nacc == 3) begin
        exp_tx.push_back(ref_alu(ops[0], ops[1], ops[2]));
        nacc = 0;
        busy = 1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  int last_rate = -1;
  bit prev_tx   = 0;

  always @(negedge clk) begin
    if (rst) begin
      last_rate = -1;
      prev_tx   = 0;
    end else begin
      if (bus.o_rate) begin
        if (last_rate >= 0) check("rate_period", cyc - last_rate, NT);
        last_rate = cyc;
      end
      if (bus.o_rx_done) begin
        if (exp_rx.size() == 0) begin
          check("rx_done_unexpected", 1, 0);
        end else begin
          int lat;
          check("rx_data", bus.o_rx_data, exp_rx.pop_front());
          lat = cyc - exp_t.pop_front();
          check("rx_latency_ok", (lat >= 750 && lat <= 780), 1);
        end
      end
      if (bus.o_tx_start) begin
        check("tx_start_width", prev_tx, 0);
        if (exp_tx.size() == 0) check("tx_start_unexpected", 1, 0);
        else check("tx_data", bus.o_data, exp_tx.pop_front());
      end
      prev_tx = bus.o_tx_start;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input logic [7:0] v, input bit good);
    int t0;
    @(negedge clk);
    bus.i_rx = 1'b0;
    t0 = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = v[i];
      repeat (BIT) @(negedge clk);
    end
    if (good) begin
      model_accept(v, t0);
      bus.i_rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      bus.i_rx = 1'b0;
      repeat (55) @(negedge clk);
      bus.i_rx = 1'b1;
      repeat (BIT - 55) @(negedge clk);
    end
    repeat (30 + $urandom_range(0, 20)) @(negedge clk);
  endtask

  task automatic pulse_tx_done();
    @(negedge clk);
    bus.i_tx_done = 1'b1;
    if (busy) busy = 0;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic triple(input logic [7:0] a, input logic [7:0] op,
                        input logic [7:0] b);
    send_frame(a, 1);
    send_frame(op, 1);
    send_frame(b, 1);
    repeat (10) @(negedge clk);
    pulse_tx_done();
  endtask

  task automatic glitch();
    @(negedge clk);
    bus.i_rx = 1'b0;
    repeat (30) @(negedge clk);
    bus.i_rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    nacc = 0;
    busy = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  logic [7:0] oplist[8] = '{8'h20, 8'h22, 8'h24, 8'h25,
                            8'h26, 8'h27, 8'h03, 8'h02};

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rop;
    int         k;
    bus.i_rx      = 1'b1;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rate",     bus.o_rate, 0);
    check("rst_rx_data",  bus.o_rx_data, 0);
    check("rst_rx_done",  bus.o_rx_done, 0);
    check("rst_data",     bus.o_data, 0);
    check("rst_tx_start", bus.o_tx_start, 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);

    triple(8'h53, 8'h20, 8'h01);
    triple(8'h05, 8'h22, 8'h07);
    triple(8'h81, 8'h03, 8'h01);

    send_frame(8'h0A, 1);
    pulse_tx_done();
    send_frame(8'h77, 0);
    glitch();
    send_frame(8'h25, 1);
    send_frame(8'h30, 1);
    send_frame(8'h99, 1);
    pulse_tx_done();

    triple(8'h12, 8'h24, 8'h3C);

    send_frame(8'h53, 1);
    send_frame(8'h20, 1);
    reset_dut();
    triple(8'h01, 8'h20, 8'h01);

    for (int t = 0; t < 6; t++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom_range(0, 9));
      if (t[0]) rb = 8'($urandom);
      k   = $urandom_range(0, 8);
      rop = (k == 8) ? 8'($urandom) : oplist[k];
      triple(ra, rop, rb);
    end

    repeat (1000) @(negedge clk);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("tx_queue_drained", exp_tx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
